// File: rtl/ee354_project_top.sv
// Snake on a 16x16 grid: buttons steer, a free-running counter paces moves,
// wall or body contact loses, LFSR-placed food grows the snake, length 16 wins.
module ee354_project_top #(
    parameter int TICK_W = 24
) (
    input  logic ClkPort,
    input  logic BtnC,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnL,
    input  logic BtnR,
    output logic Ld0,
    output logic Ld1,
    output logic Ld2,
    output logic Ld3,
    output logic An0,
    output logic An1,
    output logic An2,
    output logic An3,
    output logic An4,
    output logic An5,
    output logic An6,
    output logic An7,
    output logic Ca,
    output logic Cb,
    output logic Cc,
    output logic Cd,
    output logic Ce,
    output logic Cf,
    output logic Cg,
    output logic Dp
);

    // Counter must reach bit 17 for the digit mux even with short ticks.
    localparam int CNT_W = (TICK_W > 18) ? TICK_W : 18;

    typedef enum logic [1:0] {INI, RUN, LOSE, WIN} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

    localparam logic [127:0] SEG_INIT = {{14{8'h9A}}, 8'h99, 8'h98};
    localparam logic [7:0]   FOOD_INIT = 8'h22;
    localparam logic [7:0]   LFSR_SEED = 8'h01;

    state_t           state, state_nxt;
    dir_t             dir;
    pos_t [15:0]      seg;
    logic [4:0]       length;
    logic [7:0]       score;
    pos_t             food;
    logic [7:0]       lfsr, lfsr_nxt;
    logic [CNT_W-1:0] cnt;
    logic             disp_on;

    pos_t head_nxt;
    logic tick, wall_hit, body_hit, eat, move;

    assign tick     = (state == RUN) && (&cnt[TICK_W-1:0]);
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_comb begin
        head_nxt = seg[0];
        wall_hit = 1'b0;
        unique case (dir)
            DIR_UP: begin
                wall_hit   = (seg[0].y == 4'd0);
                head_nxt.y = seg[0].y - 4'd1;
            end
            DIR_DOWN: begin
                wall_hit   = (seg[0].y == 4'd15);
                head_nxt.y = seg[0].y + 4'd1;
            end
            DIR_LEFT: begin
                wall_hit   = (seg[0].x == 4'd0);
                head_nxt.x = seg[0].x - 4'd1;
            end
            DIR_RIGHT: begin
                wall_hit   = (seg[0].x == 4'd15);
                head_nxt.x = seg[0].x + 4'd1;
            end
        endcase
    end

    // The tail cell (length-1) is skipped: it vacates on the same move.
    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < 15; i++) begin
            if ((5'(i) < length - 5'd1) && (seg[i] == head_nxt)) body_hit = 1'b1;
        end
    end

    assign eat  = (head_nxt == food);
    assign move = tick && !wall_hit && !body_hit;

    always_comb begin
        state_nxt = state;
        unique case (state)
            INI: state_nxt = RUN;
            RUN: begin
                if (tick) begin
                    if (wall_hit || body_hit)        state_nxt = LOSE;
                    else if (eat && length == 5'd15) state_nxt = WIN;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge ClkPort or negedge BtnC) begin
        if (!BtnC) begin
            state   <= INI;
            dir     <= DIR_UP;
            seg     <= SEG_INIT;
            length  <= 5'd3;
            score   <= 8'd0;
            food    <= pos_t'(FOOD_INIT);
            lfsr    <= LFSR_SEED;
            cnt     <= '0;
            disp_on <= 1'b0;
        end else begin
            state   <= state_nxt;
            lfsr    <= lfsr_nxt;
            disp_on <= 1'b1;
            cnt     <= (state == INI) ? '0 : cnt + 1'b1;
            if (state == RUN) begin
                if (BtnU)      dir <= DIR_UP;
                else if (BtnD) dir <= DIR_DOWN;
                else if (BtnL) dir <= DIR_LEFT;
                else if (BtnR) dir <= DIR_RIGHT;
            end
            // Shifting all 16 cells keeps the old tail in seg[length] for growth.
            if (move) begin
                seg <= {seg[14:0], head_nxt};
                if (eat) begin
                    length <= length + 5'd1;
                    score  <= score + 8'd1;
                    food   <= pos_t'(lfsr_nxt);
                end
            end
        end
    end

    logic [3:0] nib;
    logic [6:0] cath;

    assign nib = cnt[17] ? score[7:4] : score[3:0];

    always_comb begin
        cath = 7'b1111111;
        unique case (nib)
            4'h0: cath = 7'b0000001;
            4'h1: cath = 7'b1001111;
            4'h2: cath = 7'b0010010;
            4'h3: cath = 7'b0000110;
            4'h4: cath = 7'b1001100;
            4'h5: cath = 7'b0100100;
            4'h6: cath = 7'b0100000;
            4'h7: cath = 7'b0001111;
            4'h8: cath = 7'b0000000;
            4'h9: cath = 7'b0000100;
            4'hA: cath = 7'b0001000;
            4'hB: cath = 7'b1100000;
            4'hC: cath = 7'b0110001;
            4'hD: cath = 7'b1000010;
            4'hE: cath = 7'b0110000;
            4'hF: cath = 7'b0111000;
        endcase
    end

    assign {Ca, Cb, Cc, Cd, Ce, Cf, Cg} = cath;
    assign Dp  = 1'b1;
    assign An0 = ~(disp_on & ~cnt[17]);
    assign An1 = ~(disp_on & cnt[17]);
    assign {An7, An6, An5, An4, An3, An2} = 6'b111111;

    assign Ld0 = (state == INI);
    assign Ld1 = (state == RUN);
    assign Ld2 = (state == LOSE);
    assign Ld3 = (state == WIN);

endmodule

// File: tb/tb_ee354_project_top.sv
// Scoreboard bench for the snake game: a reference model predicts every move,
// a monitor compares the design whenever it performs a move.
module tb_ee354_project_top;

    localparam int TW    = 4;
    localparam int TICKS = 1 << TW;
    localparam logic [3:0] L_INI = 4'b0001, L_RUN = 4'b0010, L_LOSE = 4'b0100, L_WIN = 4'b1000;

    logic clk = 1'b0, btnc = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic ld0, ld1, ld2, ld3;
    logic an0, an1, an2, an3, an4, an5, an6, an7;
    logic ca, cb, cc, cd, ce, cf, cg, dp;
    logic [3:0] ld;
    logic [7:0] an;
    logic [6:0] cath;

    assign ld   = {ld3, ld2, ld1, ld0};
    assign an   = {an7, an6, an5, an4, an3, an2, an1, an0};
    assign cath = {ca, cb, cc, cd, ce, cf, cg};

    ee354_project_top #(.TICK_W(TW)) dut (
        .ClkPort(clk), .BtnC(btnc), .BtnU(btnu), .BtnD(btnd), .BtnL(btnl), .BtnR(btnr),
        .Ld0(ld0), .Ld1(ld1), .Ld2(ld2), .Ld3(ld3),
        .An0(an0), .An1(an1), .An2(an2), .An3(an3), .An4(an4), .An5(an5), .An6(an6), .An7(an7),
        .Ca(ca), .Cb(cb), .Cc(cc), .Cd(cd), .Ce(ce), .Cf(cf), .Cg(cg), .Dp(dp)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[n];
    endfunction

    // Reference model: snake as a list of cells, head first.
    typedef struct {
        logic [3:0] ld;
        logic [7:0] head;
        int         len;
        logic [7:0] score;
        logic [7:0] food;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_state;
    logic [7:0] body [16];
    int         m_len, m_dir, m_run_clk, mticks = 0;
    logic [7:0] m_score, m_food, m_lfsr;

    task automatic model_reset();
        m_state = L_INI;
        body[0] = 8'h98;
        body[1] = 8'h99;
        for (int i = 2; i < 16; i++) body[i] = 8'h9A;
        m_len = 3; m_dir = 0; m_food = 8'h22; m_score = 8'd0; m_lfsr = 8'h01; m_run_clk = 0;
        exp_q.delete();
    endtask

    task automatic do_move(input logic [7:0] nl);
        int nx, ny;
        bit lose;
        exp_t e;
        nx = int'(body[0][7:4]);
        ny = int'(body[0][3:0]);
        case (m_dir)
            0: ny--;
            1: ny++;
            2: nx--;
            default: nx++;
        endcase
        lose = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
        for (int i = 1; i < m_len - 1; i++)
            if (!lose && body[i] == {nx[3:0], ny[3:0]}) lose = 1'b1;
        if (lose) m_state = L_LOSE;
        else begin
            for (int i = 15; i > 0; i--) body[i] = body[i-1];
            body[0] = {nx[3:0], ny[3:0]};
            if (body[0] == m_food) begin
                m_len++;
                m_score++;
                m_food = nl;
                if (m_len == 16) m_state = L_WIN;
            end
        end
        e.ld = m_state; e.head = body[0]; e.len = m_len; e.score = m_score; e.food = m_food;
        exp_q.push_back(e);
        mticks++;
    endtask

    always @(posedge clk) begin
        logic [7:0] nl;
        if (!btnc) model_reset();
        else begin
            nl = lfsr_step(m_lfsr);
            if (m_state == L_INI) begin
                m_state   = L_RUN;
                m_run_clk = 0;
            end else if (m_state == L_RUN) begin
                m_run_clk++;
                if (m_run_clk % TICKS == 0) do_move(nl);
                if (btnu)      m_dir = 0;
                else if (btnd) m_dir = 1;
                else if (btnl) m_dir = 2;
                else if (btnr) m_dir = 3;
            end
            m_lfsr = nl;
        end
    end

    // Monitor: the design's move strobe is the output event that retires one expectation.
    logic prev_tick = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_tick && btnc) begin
            check("move expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("state leds", 32'(ld), 32'(e.ld));
                check("head", 32'(dut.seg[0]), 32'(e.head));
                check("length", 32'(dut.length), 32'(e.len));
                check("score", 32'(dut.score), 32'(e.score));
                check("food", 32'(dut.food), 32'(e.food));
                check("score digit", 32'({an[1:0], cath}), 32'({2'b10, hex7(e.score[3:0])}));
            end
        end
        prev_tick = dut.tick;
    end

    task automatic press(input logic [3:0] b);
        @(negedge clk); #1 {btnu, btnd, btnl, btnr} = b;
        @(negedge clk); #1 {btnu, btnd, btnl, btnr} = 4'b0000;
    endtask

    task automatic wait_ticks(input int n);
        int target, cyc;
        target = mticks + n;
        cyc = 0;
        while (mticks < target && cyc < (n + 1) * TICKS) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1 btnc = 1'b0;
        repeat (3) @(negedge clk);
        #1 btnc = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset and release
        repeat (3) @(negedge clk);
        check("reset leds", 32'(ld), 32'(L_INI));
        check("reset anodes", 32'(an), 32'hFF);
        #1 btnc = 1'b1;
        #1 check("leds after release", 32'(ld), 32'(L_INI));
        @(negedge clk);
        check("leds one clock later", 32'(ld), 32'(L_RUN));

        // Right move, then run into the right wall
        press(4'b0001);
        wait_ticks(2);
        check("run after 2 ticks", 32'(ld), 32'(L_RUN));
        check("head after 2 right", 32'(dut.seg[0]), 32'h0B8);
        wait_ticks(5);
        check("wall loss", 32'(ld), 32'(L_LOSE));
        check("wall head frozen", 32'(dut.seg[0]), 32'h0F8);
        repeat (3 * TICKS) @(negedge clk);
        check("lose absorbing", 32'(ld), 32'(L_LOSE));

        // Reversal onto seg1
        do_reset();
        press(4'b0100);
        wait_ticks(1);
        check("self collision", 32'(ld), 32'(L_LOSE));
        check("collision head frozen", 32'(dut.seg[0]), 32'h098);

        // Eat the food at (2,2)
        do_reset();
        press(4'b0010);
        wait_ticks(7);
        check("head at (2,8)", 32'(dut.seg[0]), 32'h028);
        press(4'b1000);
        wait_ticks(6);
        check("eat length", 32'(dut.length), 32'd4);
        check("eat score", 32'(dut.score), 32'd1);
        check("digit shows 1", 32'({an[1:0], cath}), 32'({2'b10, 7'b1001111}));
        check("food from lfsr", 32'(dut.food), 32'(m_food));

        // Long snake, one more food straight ahead: win
        press(4'b0001);
        wait_ticks(4);
        check("head at (6,2)", 32'(dut.seg[0]), 32'h062);
        @(negedge clk); #1;
        force dut.length = 5'd15;
        force dut.food = 8'h72;
        m_len = 15;
        m_food = 8'h72;
        #1;
        release dut.length;
        release dut.food;
        wait_ticks(1);
        check("win leds", 32'(ld), 32'(L_WIN));
        check("win length", 32'(dut.length), 32'd16);
        repeat (2 * TICKS) @(negedge clk);
        check("win absorbing", 32'(ld), 32'(L_WIN));

        // Reset in the middle of a game
        do_reset();
        repeat (TICKS + 5) @(negedge clk);
        #1 btnc = 1'b0;
        #1;
        check("mid-game reset leds", 32'(ld), 32'(L_INI));
        check("mid-game reset head", 32'(dut.seg[0]), 32'h098);
        check("mid-game reset anodes", 32'(an), 32'hFF);
        repeat (2 * TICKS) @(negedge clk);
        check("no move while reset", 32'(dut.seg[0]), 32'h098);
        check("held in ini", 32'(ld), 32'(L_INI));
        #1 btnc = 1'b1;
        @(negedge clk);
        check("run after mid-game reset", 32'(ld), 32'(L_RUN));

        // Random button play
        for (int g = 0; g < 4; g++) begin
            do_reset();
            for (int c = 0; c < 40 * TICKS && m_state == L_RUN; c++) begin
                @(negedge clk); #1;
                if ($urandom_range(0, 5) == 0) {btnu, btnd, btnl, btnr} = 4'($urandom);
                else {btnu, btnd, btnl, btnr} = 4'b0000;
            end
            {btnu, btnd, btnl, btnr} = 4'b0000;
            repeat (2) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
